// File: rtl/bin_search_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bin_search_ctrl_pkg
//   Shared definitions for the binary-search comparison initiator.
//   - state_t     : FSM state encoding (also exported on the debug port)
//   - FLG_*       : comparator flag patterns, packed as {gt, eq, lt}
//   - flags_onehot: true when exactly one comparator flag is asserted
// -----------------------------------------------------------------------------
package bin_search_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] FLG_GT = 3'b100;
  localparam logic [2:0] FLG_EQ = 3'b010;
  localparam logic [2:0] FLG_LT = 3'b001;

  function automatic logic flags_onehot(input logic [2:0] f);
    return (f == FLG_GT) || (f == FLG_EQ) || (f == FLG_LT);
  endfunction

endpackage

// File: rtl/bin_search_ctrl.sv
// -----------------------------------------------------------------------------
// bin_search_ctrl
//   Binary-searches an unknown WIDTH-bit target held on comparator input A by
//   driving trial values on comparator input B (guess) and consuming the
//   comparator's GT/EQ/LT flags. One probe is evaluated per clock while busy.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset (wins over all)
//   start      in   1       begin a search; honoured in IDLE or DONE only
//   cmp_gt     in   1       target >  guess
//   cmp_eq     in   1       target == guess
//   cmp_lt     in   1       target <  guess
//   guess      out  WIDTH   registered trial value to comparator B
//   busy       out  1       high while evaluating probes
//   done       out  1       level, high from end of search to next start/rst
//   found      out  WIDTH   located value (valid when done && !err)
//   steps      out  STEP_W  probes evaluated in the current/last search
//   err        out  1       with done: flags not one-hot or bounds crossed
//   state_dbg  out  2       current FSM state
//
// Handshake: start is a single-cycle request sampled at the clock edge. It is
//   accepted only when busy is low (IDLE or DONE); while busy it is dropped,
//   not queued. Acceptance is visible one cycle later as busy=1, done=0.
//   The comparator flags are sampled on every edge while busy; guess is held
//   stable for the whole preceding cycle so a combinational comparator settles.
// -----------------------------------------------------------------------------
module bin_search_ctrl
  import bin_search_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_gt,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  output logic [WIDTH-1:0]  guess,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  found,
  output logic [STEP_W-1:0] steps,
  output logic              err,
  output state_t            state_dbg
);

  // Bounds are widened by two bits so guess+1 at the top and guess-1 at zero
  // neither wrap nor alias: the crossing test below is a signed compare.
  localparam int BW = WIDTH + 2;

  localparam logic [WIDTH-1:0]         MAX_VAL = '1;
  localparam logic [WIDTH-1:0]         MID_VAL = MAX_VAL >> 1;
  localparam logic signed [BW-1:0]     ONE     = BW'(1);
  localparam logic [STEP_W-1:0]        STEP1   = STEP_W'(1);

  state_t               state;
  logic [WIDTH-1:0]     lo;
  logic [WIDTH-1:0]     hi;

  logic [2:0]           flags;
  logic signed [BW-1:0] lo_x;
  logic signed [BW-1:0] hi_x;
  logic signed [BW-1:0] g_x;
  logic signed [BW-1:0] nlo;
  logic signed [BW-1:0] nhi;
  logic                 crossed;
  logic [WIDTH-1:0]     nguess;

  assign state_dbg = state;

  // Next-bound / next-guess arithmetic for a single GT or LT answer.
  always_comb begin
    flags   = {cmp_gt, cmp_eq, cmp_lt};
    lo_x    = {2'b00, lo};
    hi_x    = {2'b00, hi};
    g_x     = {2'b00, guess};
    nlo     = lo_x;
    nhi     = hi_x;
    if (flags == FLG_GT) begin
      nlo = g_x + ONE;
    end else if (flags == FLG_LT) begin
      nhi = g_x - ONE;
    end
    // An empty interval means the comparator contradicted itself.
    crossed = (nlo > nhi);
    // When not crossed both bounds lie in 0..MAX, so the sum cannot overflow BW.
    nguess  = WIDTH'((nlo + nhi) >>> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lo    <= '0;
      hi    <= '0;
      guess <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= '0;
      steps <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_EVAL;
            lo    <= '0;
            hi    <= MAX_VAL;
            guess <= MID_VAL;
            steps <= '0;
            found <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end

        ST_EVAL: begin
          steps <= steps + STEP1;
          if (!flags_onehot(flags)) begin
            // Malformed flags: stop with lo/hi/guess frozen for inspection.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (flags == FLG_EQ) begin
            state <= ST_DONE;
            found <= guess;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
          end else if (crossed) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            lo    <= nlo[WIDTH-1:0];
            hi    <= nhi[WIDTH-1:0];
            guess <= nguess;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_search_ctrl.sv
module tb_bin_search_ctrl;
  import bin_search_ctrl_pkg::*;

  localparam int WIDTH  = 8;
  localparam int STEP_W = $clog2(WIDTH + 2);
  localparam int EXP_W  = 2 + STEP_W + WIDTH;  // {chk_steps, err, steps, found}
  localparam int NV     = 11;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              cmp_gt, cmp_eq, cmp_lt;
  logic [WIDTH-1:0]  guess;
  logic              busy, done, err;
  logic [WIDTH-1:0]  found;
  logic [STEP_W-1:0] steps;
  state_t            state_dbg;

  always #5 clk = ~clk;

  bin_search_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .steps(steps), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- comparator model ----------------
  logic [WIDTH-1:0] target;
  logic             liar;
  logic             force_en;
  logic [2:0]       force_val;

  always_comb begin
    if (force_en)             {cmp_gt, cmp_eq, cmp_lt} = force_val;
    else if (liar)            {cmp_gt, cmp_eq, cmp_lt} = 3'b100;
    else if (target > guess)  {cmp_gt, cmp_eq, cmp_lt} = 3'b100;
    else if (target == guess) {cmp_gt, cmp_eq, cmp_lt} = 3'b010;
    else                      {cmp_gt, cmp_eq, cmp_lt} = 3'b001;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic             done_q = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_found", found, mon_e[WIDTH-1:0]);
        check("sb_err", err, mon_e[EXP_W-2]);
        if (mon_e[EXP_W-1]) begin
          check("sb_steps", steps, mon_e[WIDTH+STEP_W-1:WIDTH]);
        end else begin
          check("sb_steps_le9", int'(steps <= 9 && steps >= 1), 1);
        end
      end
    end
    done_q = done;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_search(input logic [WIDTH-1:0] tgt, input logic lr,
                            input logic [WIDTH-1:0] ef, input int es,
                            input logic ee, input logic chk, input logic poke);
    int cycles;
    target = tgt;
    liar   = lr;
    exp_q.push_back({chk, ee, STEP_W'(es), ef});
    pulse_start();
    check("start_clears", {done, err, busy}, 3'b001);
    cycles = 0;
    while (!done && cycles < 20) begin
      start = poke && (cycles == 2);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      check("timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else if (chk) begin
      check("latency", cycles, es);
    end
  endtask

  task automatic trace_search(input logic [WIDTH-1:0] tgt,
                              input logic [WIDTH-1:0] seq [9], input int n);
    target = tgt;
    liar   = 1'b0;
    exp_q.push_back({1'b1, 1'b0, STEP_W'(n), tgt});
    pulse_start();
    for (int i = 0; i < n; i++) begin
      check($sformatf("trace_guess_t%0d_p%0d", tgt, i), guess, seq[i]);
      check("trace_busy", busy, 1);
      @(negedge clk);
    end
    check("trace_done", done, 1);
  endtask

  // Forces a bad flag pattern on probe 'probe' of a target-42 search.
  task automatic bad_flags(input logic [2:0] pat, input int probe,
                           input logic [WIDTH-1:0] exp_guess);
    target = 8'd42;
    liar   = 1'b0;
    exp_q.push_back({1'b1, 1'b1, STEP_W'(probe), 8'd0});
    pulse_start();
    repeat (probe - 1) @(negedge clk);
    force_en  = 1'b1;
    force_val = pat;
    @(negedge clk);
    check($sformatf("bad_done_%b", pat), done, 1);
    check($sformatf("bad_err_%b", pat), err, 1);
    check($sformatf("bad_steps_%b", pat), steps, probe);
    check($sformatf("bad_guess_frozen_%b", pat), guess, exp_guess);
    force_en = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, "_guess"}, guess, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_found"}, found, 0);
    check({name, "_steps"}, steps, 0);
    check({name, "_err"}, err, 0);
    check({name, "_state"}, int'(state_dbg), int'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] target;
    logic             liar;
    logic [WIDTH-1:0] exp_found;
    int               exp_steps;
    logic             exp_err;
  } vec_t;

  vec_t vecs [NV];
  logic [WIDTH-1:0] tr255 [9];
  logic [WIDTH-1:0] tr0   [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'd127, 1'b0, 8'd127, 1, 1'b0};
    vecs[1]  = '{8'd255, 1'b0, 8'd255, 9, 1'b0};
    vecs[2]  = '{8'd0,   1'b0, 8'd0,   8, 1'b0};
    vecs[3]  = '{8'd63,  1'b0, 8'd63,  2, 1'b0};
    vecs[4]  = '{8'd191, 1'b0, 8'd191, 2, 1'b0};
    vecs[5]  = '{8'd31,  1'b0, 8'd31,  3, 1'b0};
    vecs[6]  = '{8'd1,   1'b0, 8'd1,   7, 1'b0};
    vecs[7]  = '{8'd128, 1'b0, 8'd128, 8, 1'b0};
    vecs[8]  = '{8'd254, 1'b0, 8'd254, 8, 1'b0};
    vecs[9]  = '{8'd42,  1'b0, 8'd42,  8, 1'b0};
    vecs[10] = '{8'd0,   1'b1, 8'd0,   9, 1'b1};  // always-GT comparator
    tr255 = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    tr0   = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0, 8'd0};

    rst = 1'b1; start = 1'b0; target = '0; liar = 1'b0;
    force_en = 1'b0; force_val = 3'b000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Table-driven searches, back to back (restart from DONE).
    for (int i = 0; i < NV; i++) begin
      run_search(vecs[i].target, vecs[i].liar, vecs[i].exp_found,
                 vecs[i].exp_steps, vecs[i].exp_err, 1'b1, 1'b0);
    end
    liar = 1'b0;

    // Guess sequences for the extreme targets.
    trace_search(8'd255, tr255, 9);
    trace_search(8'd0, tr0, 8);

    // Malformed flag patterns, then a clean restart.
    bad_flags(3'b000, 3, 8'd31);
    run_search(8'd42, 1'b0, 8'd42, 8, 1'b0, 1'b1, 1'b0);
    bad_flags(3'b110, 1, 8'd127);
    bad_flags(3'b111, 2, 8'd63);
    bad_flags(3'b011, 1, 8'd127);

    // Reset in the middle of a search (probe 4 of target 200).
    target = 8'd200;
    pulse_start();
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    @(negedge clk);
    check("rst_start_ignored_state", int'(state_dbg), int'(ST_IDLE));
    check("rst_start_ignored_busy", busy, 0);
    rst   = 1'b0;
    start = 1'b0;
    // Clean restart with a start pulse landing mid-search (must be ignored).
    run_search(8'd200, 1'b0, 8'd200, 8, 1'b0, 1'b1, 1'b1);

    // Exhaustive sweep.
    for (int t = 0; t < 256; t++) begin
      run_search(WIDTH'(t), 1'b0, WIDTH'(t), 0, 1'b0, 1'b0, 1'b0);
    end

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
